// File: rtl/danger_pkg.sv
// Shared constants for the obstacle renderer: type/kind codes, sprite sizes and baselines.
// Per-type geometry lookup used by every channel's geometry block.
package danger_pkg;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } dtype_e;

  typedef enum logic [1:0] {
    KIND_BIG   = 2'd0,
    KIND_SMALL = 2'd1,
    KIND_MANY  = 2'd2,
    KIND_BIRD  = 2'd3
  } kind_e;

  localparam int NUM_KIND = 4;

  localparam int BIG_W   = 27;
  localparam int BIG_H   = 50;
  localparam int SMALL_W = 19;
  localparam int SMALL_H = 36;
  localparam int MANY_W  = 77;
  localparam int MANY_H  = 49;
  localparam int BIRD_W  = 47;
  localparam int BIRD_H  = 42;

  localparam int Y_GROUND   = 298;
  localparam int Y_LOW_SKY  = 290;
  localparam int Y_HIGH_SKY = 250;

  // Second wing frame is stored directly after the first in the bird ROM.
  localparam int BIRD_FRAME_OFS = BIRD_W * BIRD_H;

  typedef struct packed {
    logic        valid;
    kind_e       kind;
    logic [10:0] w;
    logic [10:0] h;
    logic [10:0] ybase;
  } sprite_geom_t;

  function automatic sprite_geom_t type_geom(input logic [2:0] t);
    sprite_geom_t g;
    g = '{valid: 1'b0, kind: KIND_BIG, w: 11'd1, h: 11'd0, ybase: 11'd0};
    case (t)
      LOW_BIRD:     g = '{1'b1, KIND_BIRD,  11'(BIRD_W),  11'(BIRD_H),  11'(Y_LOW_SKY)};
      HIGH_BIRD:    g = '{1'b1, KIND_BIRD,  11'(BIRD_W),  11'(BIRD_H),  11'(Y_HIGH_SKY)};
      SMALL_CACTUS: g = '{1'b1, KIND_SMALL, 11'(SMALL_W), 11'(SMALL_H), 11'(Y_GROUND)};
      MANY_CACTUS:  g = '{1'b1, KIND_MANY,  11'(MANY_W),  11'(MANY_H),  11'(Y_GROUND)};
      BIG_CACTUS:   g = '{1'b1, KIND_BIG,   11'(BIG_W),   11'(BIG_H),   11'(Y_GROUND)};
      default:      g = '{valid: 1'b0, kind: KIND_BIG, w: 11'd1, h: 11'd0, ybase: 11'd0};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/danger_sprite_engine_if.sv
// Sprite ROM bus: one address/data lane per sprite kind (big, small, many, bird).
// The engine is the master; the ROM returns data one clock after the address.
interface danger_sprite_engine_if
  import danger_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
);
  logic [NUM_KIND*ADDR_W-1:0]  rom_addr;
  logic [NUM_KIND*COLOR_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/danger_geom.sv
// Per-channel obstacle geometry: decides whether the scan position falls inside the
// channel's sprite box and forms the ROM address (row*W + col, plus wing frame for birds).
module danger_geom
  import danger_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic [9:0]        pos_x_i,
  input  logic [2:0]        dtype_i,
  input  logic              den_i,
  input  logic [9:0]        h_cnt_i,
  input  logic [9:0]        v_cnt_i,
  input  logic              bird_frame_i,
  output logic              inside_o,
  output kind_e             kind_o,
  output logic [ADDR_W-1:0] addr_o
);

  sprite_geom_t g;
  logic signed [11:0] col;
  logic signed [11:0] row;

  // Signed column keeps left-clipped sprites correct: columns left of x=0 go negative.
  always_comb begin
    g   = type_geom(dtype_i);
    col = $signed({2'b00, h_cnt_i}) - ($signed({2'b00, pos_x_i}) - $signed({1'b0, g.w}));
    row = $signed({2'b00, v_cnt_i}) - ($signed({1'b0, g.ybase}) - $signed({1'b0, g.h}));
    inside_o = den_i && g.valid && (pos_x_i != 10'd0) &&
               (col >= 12'sd0) && (col < $signed({1'b0, g.w})) &&
               (row >= 12'sd0) && (row < $signed({1'b0, g.h}));
    kind_o = g.kind;
    addr_o = ADDR_W'($unsigned(row)) * ADDR_W'(g.w) + ADDR_W'($unsigned(col));
    if (bird_frame_i && (g.kind == KIND_BIRD)) begin
      addr_o = addr_o + ADDR_W'(BIRD_FRAME_OFS);
    end
  end

endmodule

// File: rtl/danger_sprite_engine.sv
// Obstacle renderer: NUM_CH channels, per-kind ROM arbitration, 2-clock composited pixel.
// Optional macro BIRD_ANIM_EN adds a frame counter that alternates the bird wing frame.
module danger_sprite_engine
  import danger_pkg::*;
#(
  parameter int                 NUM_CH      = 3,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hFFF,
  parameter int                 LATCH_LINE  = 308,
  parameter int                 ADDR_W      = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*10-1:0]  pos_x_i,
  input  logic [NUM_CH*3-1:0]   dtype_i,
  input  logic [NUM_CH-1:0]     den_i,
  input  logic [9:0]            h_cnt_i,
  input  logic [9:0]            v_cnt_i,
  danger_sprite_engine_if.master rom_bus,
  output logic [COLOR_W-1:0]    pixel_o,
  output logic [NUM_CH-1:0]     hit_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                   latch_line;
  logic [NUM_CH*10-1:0]   sh_pos_q;
  logic [NUM_CH*3-1:0]    sh_type_q;
  logic [NUM_CH-1:0]      sh_en_q;
  logic                   bird_frame;

  logic [NUM_CH-1:0]      inside_w;
  kind_e                  kind_w [NUM_CH];
  logic [ADDR_W-1:0]      addr_w [NUM_CH];

  logic [IDX_W-1:0]       owner_d [NUM_KIND];
  logic [NUM_KIND*ADDR_W-1:0] rom_addr_d;

  logic [NUM_CH-1:0]      ins_q;
  kind_e                  kind_q [NUM_CH];
  logic [IDX_W-1:0]       owner_q [NUM_KIND];
  logic [NUM_KIND*ADDR_W-1:0] rom_addr_hold_q;

  logic [COLOR_W-1:0]     sel_data;
  logic [COLOR_W-1:0]     pixel_d;
  logic [NUM_CH-1:0]      hit_d;
  logic [COLOR_W-1:0]     pixel_q;
  logic [NUM_CH-1:0]      hit_q;

  assign latch_line = (v_cnt_i == 10'(LATCH_LINE));

  // Shadow copy keeps every obstacle fixed for the whole visible frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_pos_q  <= '0;
      sh_type_q <= '0;
      sh_en_q   <= '0;
    end else if (latch_line) begin
      sh_pos_q  <= pos_x_i;
      sh_type_q <= dtype_i;
      sh_en_q   <= den_i;
    end
  end

`ifdef BIRD_ANIM_EN
  logic [4:0] frame_q;
  logic       latch_seen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q      <= '0;
      latch_seen_q <= 1'b0;
    end else begin
      latch_seen_q <= latch_line;
      if (latch_line && !latch_seen_q) begin
        frame_q <= frame_q + 5'd1;
      end
    end
  end

  assign bird_frame = frame_q[4];
`else
  assign bird_frame = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    danger_geom #(.ADDR_W(ADDR_W)) u_geom (
      .pos_x_i      (sh_pos_q[gi*10 +: 10]),
      .dtype_i      (sh_type_q[gi*3 +: 3]),
      .den_i        (sh_en_q[gi]),
      .h_cnt_i      (h_cnt_i),
      .v_cnt_i      (v_cnt_i),
      .bird_frame_i (bird_frame),
      .inside_o     (inside_w[gi]),
      .kind_o       (kind_w[gi]),
      .addr_o       (addr_w[gi])
    );
  end

  // Scan from the top channel down so the lowest inside channel wins each kind.
  always_comb begin
    rom_addr_d = rom_addr_hold_q;
    for (int k = 0; k < NUM_KIND; k++) begin
      owner_d[k] = '0;
      for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
        if (inside_w[ch] && (kind_w[ch] == kind_e'(k))) begin
          owner_d[k] = IDX_W'(ch);
          rom_addr_d[k*ADDR_W +: ADDR_W] = addr_w[ch];
        end
      end
    end
  end

  assign rom_bus.rom_addr = rom_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_q           <= '0;
      rom_addr_hold_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) kind_q[ch] <= KIND_BIG;
      for (int k = 0; k < NUM_KIND; k++) owner_q[k] <= '0;
    end else begin
      ins_q           <= inside_w;
      rom_addr_hold_q <= rom_addr_d;
      for (int ch = 0; ch < NUM_CH; ch++) kind_q[ch] <= kind_w[ch];
      for (int k = 0; k < NUM_KIND; k++) owner_q[k] <= owner_d[k];
    end
  end

  always_comb begin
    pixel_d  = TRANSPARENT;
    hit_d    = '0;
    sel_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sel_data = rom_bus.rom_data[int'(kind_q[ch])*COLOR_W +: COLOR_W];
      if (ins_q[ch] && (owner_q[kind_q[ch]] == IDX_W'(ch)) && (sel_data != TRANSPARENT)) begin
        hit_d[ch] = 1'b1;
        pixel_d   = pixel_d & sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_q <= TRANSPARENT;
      hit_q   <= '0;
    end else begin
      pixel_q <= pixel_d;
      hit_q   <= hit_d;
    end
  end

  assign pixel_o = pixel_q;
  assign hit_o   = hit_q;

endmodule
